// File: rtl/mips16_trace_tx.sv
// Debug trace transmitter: snapshots PC/instruction/ALU on each PC change and
// sends them as a checksummed 8-byte UART 8N1 frame (A5, PC, INSTR, ALU, CHK).
module mips16_trace_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  input  logic [15:0] instr_in,
  input  logic [15:0] alu_in,
  input  logic        capture_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  dropped_cnt
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [15:0]   pc_last_r, pc_buf_r, instr_buf_r, alu_buf_r;
  logic [CW-1:0] clk_cnt_r, clk_cnt_nxt_s;
  logic [2:0]    bit_idx_r, bit_idx_nxt_s, byte_idx_r, byte_idx_nxt_s;
  logic          tx_r, tx_nxt_s, busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic [7:0]    drop_r;
  logic          event_s, load_s, last_clk_s;
  logic [2:0]    bit_plus_s;
  logic [7:0]    cur_byte_s, chk_s;

  // XOR of the six payload bytes; the header is not covered
  function automatic logic [7:0] frame_chk(input logic [15:0] pc,
                                           input logic [15:0] instr,
                                           input logic [15:0] alu);
    return pc[15:8] ^ pc[7:0] ^ instr[15:8] ^ instr[7:0] ^ alu[15:8] ^ alu[7:0];
  endfunction

  assign event_s    = capture_en & (pc_in != pc_last_r);
  assign last_clk_s = (clk_cnt_r == LAST_CNT);
  assign bit_plus_s = bit_idx_r + 3'd1;
  assign chk_s      = frame_chk(pc_buf_r, instr_buf_r, alu_buf_r);

  // Select the frame byte currently on the wire
  always_comb begin
    cur_byte_s = chk_s;
    case (byte_idx_r)
      3'd0:    cur_byte_s = 8'hA5;
      3'd1:    cur_byte_s = pc_buf_r[15:8];
      3'd2:    cur_byte_s = pc_buf_r[7:0];
      3'd3:    cur_byte_s = instr_buf_r[15:8];
      3'd4:    cur_byte_s = instr_buf_r[7:0];
      3'd5:    cur_byte_s = alu_buf_r[15:8];
      3'd6:    cur_byte_s = alu_buf_r[7:0];
      default: cur_byte_s = chk_s;
    endcase
  end

  // Next-state and next-output logic; tx is computed one edge ahead so it is registered
  always_comb begin
    state_nxt_s    = state_r;
    clk_cnt_nxt_s  = clk_cnt_r;
    bit_idx_nxt_s  = bit_idx_r;
    byte_idx_nxt_s = byte_idx_r;
    tx_nxt_s       = tx_r;
    busy_nxt_s     = busy_r;
    done_nxt_s     = 1'b0;
    load_s         = 1'b0;
    case (state_r)
      IDLE: begin
        tx_nxt_s   = 1'b1;
        busy_nxt_s = 1'b0;
        if (event_s) begin
          load_s         = 1'b1;
          state_nxt_s    = START;
          clk_cnt_nxt_s  = '0;
          bit_idx_nxt_s  = 3'd0;
          byte_idx_nxt_s = 3'd0;
          tx_nxt_s       = 1'b0;
          busy_nxt_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (last_clk_s) begin
          clk_cnt_nxt_s = '0;
          state_nxt_s   = DATA;
          bit_idx_nxt_s = 3'd0;
          tx_nxt_s      = cur_byte_s[0];
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (last_clk_s) begin
          clk_cnt_nxt_s = '0;
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = STOP;
            tx_nxt_s    = 1'b1;
          end else begin
            bit_idx_nxt_s = bit_plus_s;
            tx_nxt_s      = cur_byte_s[bit_plus_s];
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (last_clk_s) begin
          clk_cnt_nxt_s = '0;
          if (byte_idx_r == 3'd7) begin
            state_nxt_s = IDLE;
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
            tx_nxt_s    = 1'b1;
          end else begin
            byte_idx_nxt_s = byte_idx_r + 3'd1;
            state_nxt_s    = START;
            tx_nxt_s       = 1'b0;
          end
        end else begin
          clk_cnt_nxt_s = clk_cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counters, snapshot buffer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pc_last_r   <= 16'h0000;
      pc_buf_r    <= 16'h0000;
      instr_buf_r <= 16'h0000;
      alu_buf_r   <= 16'h0000;
      clk_cnt_r   <= '0;
      bit_idx_r   <= 3'd0;
      byte_idx_r  <= 3'd0;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      drop_r      <= 8'd0;
    end else begin
      state_r    <= state_nxt_s;
      pc_last_r  <= pc_in;
      clk_cnt_r  <= clk_cnt_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      byte_idx_r <= byte_idx_nxt_s;
      tx_r       <= tx_nxt_s;
      busy_r     <= busy_nxt_s;
      done_r     <= done_nxt_s;
      if (load_s) begin
        pc_buf_r    <= pc_in;
        instr_buf_r <= instr_in;
        alu_buf_r   <= alu_in;
      end else begin
        pc_buf_r    <= pc_buf_r;
        instr_buf_r <= instr_buf_r;
        alu_buf_r   <= alu_buf_r;
      end
      // Completion edge is still STOP, so events there count as dropped
      if (event_s && (state_r != IDLE) && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'd1;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;
  assign dropped_cnt = drop_r;

endmodule

// File: doc/mips16_trace_tx.md
# mips16_trace_tx

Debug trace transmitter for the 16-bit single-cycle MIPS core. It watches the core's `pc_out`, `instr_test` and `alu_result` outputs and detects each retired instruction as a PC change. For each retired instruction it snapshots the three values and serialises them as a checksummed 8-byte frame on a UART 8N1 line. This lets the state a bench prints with `$monitor` be captured from hardware. It sits beside `mips_16` at the top level, and only its `tx` pin leaves the FPGA.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range ≥ 2.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc_in`  in  16  core program counter (`pc_out`).
- `instr_in`  in  16  current instruction (`instr_test`).
- `alu_in`  in  16  core ALU result.
- `capture_en`  in  1  when high, PC changes start frames; when low, they are ignored.
- `tx`  out  1  UART serial output, idle high.
- `busy`  out  1  high from frame accept to end of the last stop bit.
- `frame_done`  out  1  one-cycle pulse at frame completion.
- `dropped_cnt`  out  8  count of PC changes lost while busy; saturates at 255.

## Operation
- Change detect:
  - `pc_last` is a register loaded with `pc_in` on every edge, unconditionally.
  - An event occurs at an edge where `capture_en`=1 and `pc_in` != `pc_last`.
  - Because `pc_last` resets to 0x0000, the core's reset PC of 0 produces no event.
- Accept: if an event occurs while the FSM is IDLE, the block latches `pc_in`, `instr_in` and `alu_in` into the frame buffer.
- Drop: if an event occurs while the FSM is not IDLE, `dropped_cnt` increments (saturating) and the frame in progress is unaffected.
- Frame bytes, in order:
  - 0xA5
  - PC[15:8], PC[7:0]
  - INSTR[15:8], INSTR[7:0]
  - ALU[15:8], ALU[7:0]
  - CHK = XOR of the six payload bytes (the header is excluded).
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1).
- Bytes are sent back-to-back with no idle gap.
- FSM states: IDLE, START, DATA, STOP. A 3-bit byte index and a 3-bit bit index advance through the frame.
  - IDLE → START on accept.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START for the next byte, or STOP → IDLE after byte 7.
- If `capture_en` falls mid-frame, the current frame still completes.
- Input changes after the snapshot do not alter frame contents.
- Reset values, all applied asynchronously while `reset`=0:
  - `tx`=1, `busy`=0, `frame_done`=0, `dropped_cnt`=0.
  - `pc_last`=0, FSM in IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately: `tx` returns high and no `frame_done` pulse is generated.

## Timing
- All outputs are registered.
- Accept edge E: at E, `busy` rises and `tx` falls (start bit of byte 0). Latency from the event edge to the start bit is 0 cycles.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. Each byte lasts 10·`CLKS_PER_BIT` cycles; the frame lasts 80·`CLKS_PER_BIT` cycles.
- At edge E+80·`CLKS_PER_BIT`: `busy` falls, `tx` stays 1, and `frame_done` is 1 for exactly one cycle.
- Events on that completion edge are counted as dropped, because the FSM is still in STOP at that edge.
- The earliest new accept is the following edge.
- If an event and reset deassertion coincide, the event is ignored: the first capturing edge is the one after `reset` is sampled high.
- `dropped_cnt` at 255 holds at 255; it never wraps.

## Test plan
- Single frame, `CLKS_PER_BIT`=4:
  - Stimulus: PC 0x0000→0x0002 with instr 0x1234, alu 0x0005.
  - Required: `tx` decodes to A5 00 02 12 34 00 05 21.
  - Required: `busy` stays high for 320 cycles, then `frame_done` pulses once.
- Back-to-back retire:
  - Stimulus: PC changes on three consecutive edges.
  - Required: only the first is framed, and `dropped_cnt`=2.
  - Stimulus: hold PC constant for 300 more cycles.
  - Required: no further frame is sent.
- Saturation: 300 PC changes during one frame → `dropped_cnt`=255.
- `capture_en`=0 with PC stepping 0→2→4 → no frame, `tx` stays 1, `dropped_cnt`=0. Then raise `capture_en` and step PC to 6 → one frame is sent with PC bytes 00 06.
- Reset mid-frame:
  - Stimulus: assert `reset`=0 at cycle 100 of a frame.
  - Required: `tx`=1, `busy`=0 and `dropped_cnt`=0 asynchronously, with no `frame_done` pulse.
  - Stimulus: after release, step PC to 0x0008.
  - Required: a fresh, correct frame is sent.
- Completion-edge event: a PC change exactly on the `frame_done` edge is dropped (`dropped_cnt`+1). A PC change one cycle later starts a new frame.
